// File: rtl/snake_pkg.sv
// snake_pkg: constants and types shared by the snake step timer files.
//   WIDTH            - count/limit width, equal to the downstream comparator width
//   DEFAULT_MAX      - limit loaded on reset
//   DEFAULT_PRESCALE - clock cycles per count step
//   state_t          - timer FSM state
package snake_pkg;
  localparam int WIDTH = 10;
  localparam logic [WIDTH-1:0] DEFAULT_MAX = 10'd3;
  localparam int DEFAULT_PRESCALE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: modulo-PRESCALE cycle counter.
//   clk    - system clock
//   rst    - synchronous active-high reset
//   en     - advance the counter this cycle
//   clr    - return the counter to 0 (used while the timer is idle)
//   strobe - high on the enabled cycle where the counter is at PRESCALE-1
module step_prescaler #(
  parameter int PRESCALE = snake_pkg::DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic strobe
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_reg;

  // With PRESCALE=1, LAST is 0 and the strobe fires on every enabled cycle.
  assign strobe = en && (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
    end
  end
endmodule

// File: rtl/snake_step_timer.sv
// snake_step_timer: programmable step timer feeding the snake movement comparator.
//   clk        - system clock
//   rst        - synchronous active-high reset
//   start      - IDLE -> RUN
//   stop       - any state -> IDLE (beats start)
//   pause      - level; freezes the timer while high
//   max_in     - new limit value
//   max_load   - strobe capturing max_in (immediate in IDLE, at next wrap otherwise)
//   count      - running step count (comparator addout)
//   max_active - limit in force (comparator max)
//   tick       - one-cycle pulse after each wrap
//   running    - high in RUN or HOLD
module snake_step_timer #(
  parameter int WIDTH = snake_pkg::WIDTH,
  parameter int PRESCALE = snake_pkg::DEFAULT_PRESCALE,
  parameter logic [WIDTH-1:0] DEFAULT_MAX = WIDTH'(snake_pkg::DEFAULT_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] max_in,
  input  logic             max_load,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] max_active,
  output logic             tick,
  output logic             running
);
  import snake_pkg::*;

  state_t           state_reg;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] max_reg;
  logic [WIDTH-1:0] shadow_reg;
  logic             pending_reg;
  logic             tick_reg;

  logic run_state;
  logic advance;
  logic clear;
  logic strobe;
  logic wrap;

  assign run_state = (state_reg != IDLE);
  // The prescaler only moves on edges where pause is low, so a pause of N
  // cycles delays every later step by exactly N cycles.
  assign advance = run_state && !stop && !pause;
  assign clear   = !run_state || stop;
  assign wrap    = strobe && (count_reg == max_reg);

  step_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (advance),
    .clr    (clear),
    .strobe (strobe)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      max_reg     <= DEFAULT_MAX;
      shadow_reg  <= DEFAULT_MAX;
      pending_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          count_reg <= '0;
          if (max_load) begin
            max_reg     <= max_in;
            shadow_reg  <= max_in;
            pending_reg <= 1'b0;
          end
          if (start && !stop) begin
            state_reg <= RUN;
          end
        end
        default: begin
          if (stop) begin
            // A wrap due on this edge is dropped along with its tick.
            state_reg <= IDLE;
            count_reg <= '0;
            if (max_load) begin
              shadow_reg  <= max_in;
              pending_reg <= 1'b1;
            end
          end else begin
            state_reg <= pause ? HOLD : RUN;
            if (wrap) begin
              count_reg   <= '0;
              tick_reg    <= 1'b1;
              pending_reg <= 1'b0;
              // A load landing on the wrap edge is the newest value and wins.
              if (max_load) begin
                max_reg    <= max_in;
                shadow_reg <= max_in;
              end else if (pending_reg) begin
                max_reg <= shadow_reg;
              end
            end else begin
              if (strobe) begin
                count_reg <= count_reg + WIDTH'(1);
              end
              if (max_load) begin
                shadow_reg  <= max_in;
                pending_reg <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign count      = count_reg;
  assign max_active = max_reg;
  assign tick       = tick_reg;
  assign running    = run_state;
endmodule

// File: tb/tb_snake_step_timer.sv
module tb_snake_step_timer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [9:0] max_in = '0;
  logic       max_load = 1'b0;
  logic [9:0] count;
  logic [9:0] max_active;
  logic       tick;
  logic       running;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  snake_step_timer #(.WIDTH(10), .PRESCALE(4), .DEFAULT_MAX(10'd3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .max_in     (max_in),
    .max_load   (max_load),
    .count      (count),
    .max_active (max_active),
    .tick       (tick),
    .running    (running)
  );

  typedef struct {
    int         rep;
    logic       st;
    logic       sp;
    logic       pa;
    logic       ld;
    logic [9:0] mi;
    logic [9:0] ec;
    logic [9:0] em;
    logic       et;
    logic       er;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int rep, input logic st, input logic sp, input logic pa,
                     input logic ld, input logic [9:0] mi, input logic [9:0] ec,
                     input logic [9:0] em, input logic et, input logic er);
    vec_t v;
    v.rep = rep; v.st = st; v.sp = sp; v.pa = pa; v.ld = ld; v.mi = mi;
    v.ec = ec; v.em = em; v.et = et; v.er = er;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [9:0] ec, input logic [9:0] em,
                       input logic et, input logic er);
    n_cmp += 4;
    if (count !== ec) begin
      n_bad++;
      $display("FAIL %s count: got %0d want %0d", name, count, ec);
    end
    if (max_active !== em) begin
      n_bad++;
      $display("FAIL %s max_active: got %0d want %0d", name, max_active, em);
    end
    if (tick !== et) begin
      n_bad++;
      $display("FAIL %s tick: got %0b want %0b", name, tick, et);
    end
    if (running !== er) begin
      n_bad++;
      $display("FAIL %s running: got %0b want %0b", name, running, er);
    end
    $display("%0t %s count=%0d max=%0d tick=%0b running=%0b", $time, name, count, max_active,
             tick, running);
  endtask

  // One clock edge with the given inputs held; outputs settle by #1 after it.
  task automatic cyc(input logic st, input logic sp, input logic pa, input logic ld,
                     input logic [9:0] mi);
    start = st; stop = sp; pause = pa; max_load = ld; max_in = mi;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; max_load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    rst = 1'b0;
  endtask

  initial begin
    // Edge offsets in comments are relative to the start edge E0 / E1.
    add(1, 0,0,0,0, 0,   0, 3, 0, 0);  // idle after reset
    add(1, 1,0,0,0, 0,   0, 3, 0, 1);  // E0 start
    add(3, 0,0,0,0, 0,   0, 3, 0, 1);  // E0+3
    add(1, 0,0,0,0, 0,   1, 3, 0, 1);  // E0+4
    add(4, 0,0,0,0, 0,   2, 3, 0, 1);  // E0+8
    add(4, 0,0,0,0, 0,   3, 3, 0, 1);  // E0+12
    add(3, 0,0,0,0, 0,   3, 3, 0, 1);  // E0+15 no tick yet
    add(1, 0,0,0,0, 0,   0, 3, 1, 1);  // E0+16 first tick
    add(1, 0,0,0,0, 0,   0, 3, 0, 1);  // E0+17 single cycle
    add(8, 0,0,0,0, 0,   2, 3, 0, 1);  // E0+25
    add(1, 0,0,0,1, 1,   2, 3, 0, 1);  // E0+26 load 1 while count=2
    add(5, 0,0,0,0, 0,   3, 3, 0, 1);  // E0+31 still counts to 3
    add(1, 0,0,0,0, 0,   0, 1, 1, 1);  // E0+32 wrap applies max=1
    add(4, 0,0,0,0, 0,   1, 1, 0, 1);  // E0+36
    add(3, 0,0,0,0, 0,   1, 1, 0, 1);  // E0+39
    add(1, 0,0,0,0, 0,   0, 1, 1, 1);  // E0+40 8-cycle spacing
    add(8, 0,0,0,0, 0,   0, 1, 1, 1);  // E0+48
    add(7, 0,0,0,0, 0,   1, 1, 0, 1);  // E0+55
    add(1, 0,0,0,1, 2,   0, 2, 1, 1);  // E0+56 load on wrap edge applies now
    add(11,0,0,0,0, 0,   2, 2, 0, 1);  // E0+67
    add(1, 0,0,0,0, 0,   0, 2, 1, 1);  // E0+68 12-cycle spacing
    add(1, 0,0,0,1, 5,   0, 2, 0, 1);  // E0+69 load 5
    add(1, 0,0,0,1, 1,   0, 2, 0, 1);  // E0+70 load 1 overwrites
    add(10,0,0,0,0, 0,   0, 1, 1, 1);  // E0+80 last load wins
    add(1, 0,1,0,0, 0,   0, 1, 0, 0);  // stop
    add(1, 0,0,0,1, 0,   0, 0, 0, 0);  // IDLE load applies immediately
    add(1, 1,1,0,0, 0,   0, 0, 0, 0);  // start+stop in IDLE stays IDLE
    add(1, 1,0,0,0, 0,   0, 0, 0, 1);  // E1 start with max 0
    add(3, 0,0,0,0, 0,   0, 0, 0, 1);  // E1+3
    add(1, 0,0,0,0, 0,   0, 0, 1, 1);  // E1+4 tick every strobe
    add(4, 0,0,0,0, 0,   0, 0, 1, 1);  // E1+8
    add(1, 0,0,0,0, 0,   0, 0, 0, 1);  // E1+9
    add(2, 0,0,0,0, 0,   0, 0, 0, 1);  // E1+11
    add(1, 1,1,0,0, 0,   0, 0, 0, 0);  // E1+12 start+stop at wrap: tick suppressed

    do_reset();
    check("reset", 10'd0, 10'd3, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      for (int r = 0; r < vq[i].rep; r++) cyc(vq[i].st, vq[i].sp, vq[i].pa, vq[i].ld, vq[i].mi);
      check($sformatf("vec%0d", i), vq[i].ec, vq[i].em, vq[i].et, vq[i].er);
    end

    // Pause at count=2, prescaler=1 for 7 cycles: tick moves from E0+16 to E0+23.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    idle(9);
    check("pause_pre", 10'd2, 10'd3, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
      check($sformatf("pause_hold%0d", k), 10'd2, 10'd3, 1'b0, 1'b1);
    end
    pause = 1'b0;
    idle(6);
    check("pause_e22", 10'd3, 10'd3, 1'b0, 1'b1);
    idle(1);
    check("pause_e23", 10'd0, 10'd3, 1'b1, 1'b1);

    // Reset mid-run with a pending load of 7 falls back to the default period.
    idle(5);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 10'd7);
    idle(2);
    do_reset();
    check("rst_mid", 10'd0, 10'd3, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
    idle(15);
    check("rst_e15", 10'd3, 10'd3, 1'b0, 1'b1);
    idle(1);
    check("rst_e16", 10'd0, 10'd3, 1'b1, 1'b1);
    idle(16);
    check("rst_e32", 10'd0, 10'd3, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/snake_step_timer.md
# snake_step_timer

Programmable step timer that sits directly upstream of the 10-bit equality comparator in the snake movement path. It produces the running 10-bit count (the comparator's `addout` operand) and the active limit (its `max` operand). It also generates the registered wrap/tick pulse that advances the snake by one cell. A prescaler divides the system clock so each count step spans `PRESCALE` cycles. A shadow register lets game logic change speed without glitching a step in progress.

## Interface
- `WIDTH`, 10: count and limit width; must match comparator width.
- `PRESCALE`, 4: clock cycles per count step; legal range 1..65535.
- `DEFAULT_MAX`, 10'd3: limit loaded on reset.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, synchronous, active-high; one clock, reset is synchronous and active-high.
- `start` in 1: level/pulse; IDLE→RUN.
- `stop` in 1: pulse; any state→IDLE.
- `pause` in 1: level; while high in RUN, enter/hold HOLD.
- `max_in` in WIDTH: new limit value.
- `max_load` in 1: one-cycle strobe capturing `max_in` into shadow.
- `count` out WIDTH: current step count (to comparator `addout`).
- `max_active` out WIDTH: limit in force (to comparator `max`).
- `tick` out 1: one-cycle pulse at each wrap.
- `running` out 1: high in RUN or HOLD.

## Operation
- States: IDLE, RUN, HOLD.
  - IDLE: count=0, prescaler=0, tick=0.
  - IDLE→RUN on `start`.
  - RUN→HOLD while `pause`.
  - HOLD→RUN when `pause` low.
  - RUN/HOLD→IDLE on `stop`.
- Priority: `rst` > `stop` > `start` > `pause`. Simultaneous `start`+`stop` in IDLE stays IDLE.
- RUN: prescaler increments each cycle. At prescaler=PRESCALE-1 a step strobe occurs and the prescaler returns to 0.
- On strobe with count≠max_active: count←count+1.
- On strobe with count==max_active: count←0, tick←1 next cycle, max_active←shadow if pending.
- HOLD: count, prescaler and max_active frozen; tick forced 0. Resume continues from the frozen prescaler value; no step is lost or added.
- `max_load`: shadow←max_in, pending←1. Takes effect only at the next wrap.
  - Load on the same edge as a wrap: the newly loaded value is applied at that wrap.
  - A second load before the wrap overwrites the shadow (last wins).
- `max_load` in IDLE applies immediately to max_active (pending cleared).
- max_active=0: tick on every strobe; count stays 0.
- New limit below current count cannot occur mid-step because of the shadow; count never exceeds max_active.
- Unsigned arithmetic only; count increment never overflows WIDTH because wrap happens at max_active ≤ 2^WIDTH−1.

## Timing
- Reset values: count=0, max_active=DEFAULT_MAX, shadow=DEFAULT_MAX, pending=0, tick=0, running=0, state IDLE, prescaler=0.
- Reset mid-operation discards pending load and any in-flight tick.
- `start` sampled at edge E0: running=1 and count=0 after E0.
- First tick is high after edge E0+(max_active+1)·PRESCALE, for exactly one cycle. Subsequent ticks follow every (max_active+1)·PRESCALE cycles.
- count, max_active, tick and running are all registered; zero combinational input→output paths.
- `stop` sampled at edge E: running=0, count=0 and tick=0 after E. A tick due on the same edge is suppressed.

## Structure
- Shared package `snake_pkg`: WIDTH constant (10), state enum {IDLE, RUN, HOLD}, DEFAULT_MAX, DEFAULT_PRESCALE.
- One sub-module: `step_prescaler`, a modulo-PRESCALE counter with enable and clear, emitting `strobe`. PRESCALE=1 gives strobe every enabled cycle.
- Top holds FSM, count, shadow/pending and tick registers.

## Test plan
- Reset, then start with PRESCALE=4, max=3 -> tick high after 16th edge, then every 16 cycles; count sequence 0,1,2,3 each held 4 cycles.
- max_load max_in=1 while count=2 -> wrap still at 3. Next period counts 0,1; tick spacing becomes 8 cycles; max_active changes only at the wrap edge.
- pause high for 7 cycles at count=2, prescaler=1 -> count/prescaler frozen, no tick. After release the tick arrives exactly 7 cycles late.
- max_load max_in=0 in IDLE, then start -> tick every 4 cycles, count always 0.
- start and stop asserted together in RUN at wrap edge -> IDLE, tick stays 0, count=0.
- rst pulsed mid-RUN with pending load=7 -> all outputs at reset values. After restart, period uses DEFAULT_MAX=3 (16 cycles).
